sdiv_iter: RTL and testbench

- Sequential signed (two's-complement) divider; the inverse companion of the generated signed array multipliers.
- Takes a 2*WIDTH-bit dividend (product width) and a WIDTH-bit divisor. Returns a WIDTH-bit quotient and remainder.
- Restoring radix-2 algorithm on magnitudes, one quotient bit per cycle, valid/ready handshakes on both sides.
- Used to check and invert multiplier results and as a datapath divide unit.

---
 rtl/sdiv_pkg.sv | 39 +++
 rtl/sdiv_step.sv | 28 ++
 rtl/sdiv_iter.sv | 198 +++++++++++++++++++
 tb/tb_sdiv_iter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdiv_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sdiv_pkg : state encoding and width/sign helpers for the sdiv_iter divider  |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
package sdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_e;

  // Helpers work on a fixed wide container; callers cast back to their width.
  localparam int HELPER_W = 64;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  function automatic logic [HELPER_W-1:0] cond_neg(input logic [HELPER_W-1:0] v,
                                                   input logic neg);
    return neg ? (~v + {{(HELPER_W-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Two's-complement magnitude of a zero-extended value whose sign bit is given.
  function automatic logic [HELPER_W-1:0] magnitude(input logic [HELPER_W-1:0] v,
                                                    input logic sign_bit);
    return cond_neg(v, sign_bit);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdiv_step.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sdiv_step : one combinational restoring-division step (shift, compare, sub) |
// | Revision  : 1.0                                                             |
// +-----------------------------------------------------------------------------+
module sdiv_step
  import sdiv_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   r_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   r_o,
  output logic             qbit_o
);

  logic [WIDTH+1:0] w_t;
  logic [WIDTH+1:0] w_dvs;

  assign w_t    = {r_i, bit_i};
  assign w_dvs  = {2'b00, dvs_i};
  assign qbit_o = (w_t >= w_dvs);
  // The partial remainder stays below the divisor, so the top bit never carries data.
  assign r_o    = qbit_o ? (WIDTH+1)'(w_t - w_dvs) : (WIDTH+1)'(w_t);

endmodule
`default_nettype wire

// File: rtl/sdiv_iter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sdiv_iter : sequential signed restoring divider, 2*WIDTH / WIDTH -> WIDTH   |
// | Optional  : SDIV_ITER_ABORT_EN adds an abort input for PREP/CALC            |
// | Revision  : 1.0                                                             |
// +-----------------------------------------------------------------------------+
module sdiv_iter
  import sdiv_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
`ifdef SDIV_ITER_ABORT_EN
  input  logic               abort,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               overflow,
  output logic               div_by_zero
);

  localparam int CNT_W = clog2(WIDTH);

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   dmag_q, dmag_d;
  logic [WIDTH:0]     r_q, r_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-2:0]   qmag_q, qmag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               overflow_q, overflow_d;
  logic               dbz_q, dbz_d;

  logic [2*WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0]   w_dvs_mag;
  logic [WIDTH:0]     w_step_r;
  logic               w_step_qbit;
  logic [WIDTH-1:0]   w_qfull;
  logic [WIDTH-1:0]   w_qlim;
  logic               w_fit_ovf;

  assign w_dvd_mag = (2*WIDTH)'(magnitude(HELPER_W'(dvd_q), dvd_q[2*WIDTH-1]));
  assign w_dvs_mag = WIDTH'(magnitude(HELPER_W'(dvs_q), dvs_q[WIDTH-1]));

  sdiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r_i    (r_q),
    .bit_i  (lo_q[WIDTH-1]),
    .dvs_i  (dmag_q),
    .r_o    (w_step_r),
    .qbit_o (w_step_qbit)
  );

  // The last quotient bit is only known on the final step, so the fit check
  // looks at the register contents plus the bit being produced now.
  assign w_qfull   = {qmag_q, w_step_qbit};
  assign w_qlim    = {1'b1, {(WIDTH-1){1'b0}}};
  assign w_fit_ovf = qneg_q ? (w_qfull > w_qlim) : (w_qfull >= w_qlim);

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    dmag_d      = dmag_q;
    r_d         = r_q;
    lo_d        = lo_q;
    qmag_d      = qmag_q;
    cnt_d       = cnt_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    overflow_d  = overflow_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          state_d = PREP;
        end
      end
      PREP: begin
        qneg_d = dvd_q[2*WIDTH-1] ^ dvs_q[WIDTH-1];
        rneg_d = dvd_q[2*WIDTH-1];
        dmag_d = w_dvs_mag;
        r_d    = {1'b0, w_dvd_mag[2*WIDTH-1:WIDTH]};
        lo_d   = w_dvd_mag[WIDTH-1:0];
        qmag_d = '0;
        cnt_d  = CNT_W'(WIDTH - 1);
        if (dvs_q == '0) begin
          dbz_d       = 1'b1;
          overflow_d  = 1'b1;
          quotient_d  = '0;
          remainder_d = '0;
          state_d     = DONE;
        end else if (w_dvd_mag[2*WIDTH-1:WIDTH] >= w_dvs_mag) begin
          dbz_d       = 1'b0;
          overflow_d  = 1'b1;
          quotient_d  = '0;
          remainder_d = '0;
          state_d     = DONE;
        end else begin
          state_d = CALC;
        end
      end
      CALC: begin
        r_d    = w_step_r;
        lo_d   = lo_q << 1;
        qmag_d = (WIDTH-1)'({qmag_q, w_step_qbit});
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          dbz_d      = 1'b0;
          overflow_d = w_fit_ovf;
          if (w_fit_ovf) begin
            quotient_d  = '0;
            remainder_d = '0;
          end else begin
            quotient_d  = WIDTH'(cond_neg(HELPER_W'(w_qfull), qneg_q));
            remainder_d = WIDTH'(cond_neg(HELPER_W'(w_step_r), rneg_q));
          end
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef SDIV_ITER_ABORT_EN
    if (abort && (state_q == PREP || state_q == CALC)) begin
      state_d     = IDLE;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      overflow_d  = overflow_q;
      dbz_d       = dbz_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      dmag_q      <= '0;
      r_q         <= '0;
      lo_q        <= '0;
      qmag_q      <= '0;
      cnt_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      overflow_q  <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      dmag_q      <= dmag_d;
      r_q         <= r_d;
      lo_q        <= lo_d;
      qmag_q      <= qmag_d;
      cnt_q       <= cnt_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      overflow_q  <= overflow_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign overflow    = overflow_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_sdiv_iter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_sdiv_iter : scoreboard bench for sdiv_iter (WIDTH=4) with integer model  |
// | Revision     : 1.0                                                          |
// +-----------------------------------------------------------------------------+
module tb_sdiv_iter;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         ovf;
    logic         dbz;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*W-1:0] dividend = '0;
  logic [W-1:0]   divisor = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           overflow;
  logic           div_by_zero;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   rdy_mode = 1'b0;
  logic rdy_val = 1'b1;

  always #5 clk = ~clk;

  sdiv_iter #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef SDIV_ITER_ABORT_EN
    .abort       (1'b0),
`endif
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  // Signed integer division of the full-width operands, then range check.
  function automatic exp_t model(input logic [2*W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   ai, bi, qi, ri;
    ai = int'($signed(a));
    bi = int'($signed(b));
    e  = '0;
    if (bi == 0) begin
      e.ovf = 1'b1;
      e.dbz = 1'b1;
    end else begin
      qi = ai / bi;
      ri = ai % bi;
      if (qi > (2 ** (W - 1)) - 1 || qi < -(2 ** (W - 1))) begin
        e.ovf = 1'b1;
      end else begin
        e.q = qi[W-1:0];
        e.r = ri[W-1:0];
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    out_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_val;
  end

  // Monitor: every accepted result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL result_unexpected: got q=%0h r=%0h ovf=%0b dbz=%0b with empty scoreboard",
                 quotient, remainder, overflow, div_by_zero);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (quotient !== e.q || remainder !== e.r || overflow !== e.ovf || div_by_zero !== e.dbz) begin
          n_err++;
          $display("FAIL result: got q=%0h r=%0h ovf=%0b dbz=%0b expected q=%0h r=%0h ovf=%0b dbz=%0b",
                   quotient, remainder, overflow, div_by_zero, e.q, e.r, e.ovf, e.dbz);
        end
      end
    end
  end

  task automatic start(input logic [2*W-1:0] a, input logic [W-1:0] b, input bit push);
    int g;
    g = 0;
    while (!in_ready && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (push) sb.push_back(model(a, b));
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [2*W-1:0] d_a [6] = '{8'd42, 8'hD5, 8'd56, 8'd56, 8'd13, 8'h80};
    logic [W-1:0]   d_b [6] = '{4'd7, 4'd7, 4'h9, 4'd7, 4'd0, 4'hF};
    int             d_lat [6] = '{5, 5, 5, 5, 1, 1};
    logic [W-1:0]   d_q [6] = '{4'h6, 4'hA, 4'h8, 4'h0, 4'h0, 4'h0};
    logic [W-1:0]   d_r [6] = '{4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
    logic           d_o [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic           d_z [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int             lat;
    int             g;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_quotient", 32'(quotient), 32'd0);
    chk("reset_remainder", 32'(remainder), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_div_by_zero", 32'(div_by_zero), 32'd0);

    for (int i = 0; i < 6; i++) begin
      start(d_a[i], d_b[i], 1'b1);
      wait_valid(lat);
      chk($sformatf("latency_%0d", i), 32'(lat), 32'(d_lat[i]));
      chk($sformatf("quotient_%0d", i), 32'(quotient), 32'(d_q[i]));
      chk($sformatf("remainder_%0d", i), 32'(remainder), 32'(d_r[i]));
      chk($sformatf("overflow_%0d", i), 32'(overflow), 32'(d_o[i]));
      chk($sformatf("div_by_zero_%0d", i), 32'(div_by_zero), 32'(d_z[i]));
      @(posedge clk);
      #1;
    end

    // Back-pressure: result must hold while the consumer stalls.
    rdy_val = 1'b0;
    @(posedge clk);
    #1;
    start(8'd42, 4'd7, 1'b1);
    wait_valid(lat);
    chk("stall_latency", 32'(lat), 32'd5);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall_out_valid_%0d", k), 32'(out_valid), 32'd1);
      chk($sformatf("stall_in_ready_%0d", k), 32'(in_ready), 32'd0);
      chk($sformatf("stall_quotient_%0d", k), 32'(quotient), 32'h6);
      chk($sformatf("stall_remainder_%0d", k), 32'(remainder), 32'h0);
    end
    rdy_val = 1'b1;
    @(posedge clk);
    #1;
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);

    // Reset during the second CALC cycle aborts the operation.
    start(8'd42, 4'd7, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midreset_out_valid", 32'(out_valid), 32'd0);
    chk("midreset_in_ready", 32'(in_ready), 32'd1);
    chk("midreset_quotient", 32'(quotient), 32'd0);
    chk("midreset_remainder", 32'(remainder), 32'd0);
    chk("midreset_overflow", 32'(overflow), 32'd0);
    start(8'd42, 4'd6, 1'b1);
    wait_valid(lat);
    chk("after_reset_latency", 32'(lat), 32'd5);
    chk("after_reset_quotient", 32'(quotient), 32'h7);
    chk("after_reset_remainder", 32'(remainder), 32'h0);
    @(posedge clk);
    #1;

    // Randomised traffic with random consumer back-pressure.
    rdy_mode = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic [2*W-1:0] a;
      logic [W-1:0]   b;
      a = (2*W)'($urandom);
      b = W'($urandom);
      if ($urandom_range(0, 1) == 1) a = (2*W)'($signed(a) >>> 3);
      start(a, b, 1'b1);
    end
    g = 0;
    while (sb.size() > 0 && g < 500) begin
      @(posedge clk);
      g++;
    end
    chk("drain_scoreboard", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
